// File: rtl/gtfraw_vnc_sync_fifo_bram_if.sv
// Handshake/bus bundle for the GTF raw-data FWFT FIFO.
// afull/aempty exist only when GTFRAW_VNC_FIFO_WATERMARK_EN is defined.
interface gtfraw_vnc_sync_fifo_bram_if #(
    parameter int DATA_WIDTH = 74,
    parameter int ADDR_WIDTH = 9
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  clr_ovf;
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
    logic                  afull;
    logic                  aempty;
`endif

    // Read handshake: a word moves when rd_valid & rd_ready at posedge; while rd_valid is
    // high and rd_ready low, rd_data/rd_valid hold; rd_valid only falls after a transfer.
    modport master (
        output wr_en, wr_data, rd_ready, clr_ovf,
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
        input  afull, aempty,
`endif
        input  full, rd_data, rd_valid, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_ready, clr_ovf,
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
        output afull, aempty,
`endif
        output full, rd_data, rd_valid, level, overflow
    );
endinterface

// File: rtl/gtfraw_vnc_sync_fifo_bram.sv
// Single-clock first-word-fall-through FIFO on inferred block RAM with a 2-entry prefetch stage.
// Optional watermarks (afull/aempty) are enabled by defining GTFRAW_VNC_FIFO_WATERMARK_EN.
module gtfraw_vnc_sync_fifo_bram #(
    parameter int DATA_WIDTH   = 74,
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = 9
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
    ,
    parameter int AFULL_LEVEL  = DEPTH - 8,
    parameter int AEMPTY_LEVEL = 8
`endif
) (
    input  logic                       clk,
    input  logic                       rstn,
    gtfraw_vnc_sync_fifo_bram_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;

    generate
        if ((2 ** ADDR_WIDTH) != DEPTH) begin : g_bad_addr_width
            $error("gtfraw_vnc_sync_fifo_bram: 2**ADDR_WIDTH must equal DEPTH");
        end
        if (DEPTH < 4) begin : g_bad_depth
            $error("gtfraw_vnc_sync_fifo_bram: DEPTH must be at least 4");
        end
    endgenerate

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [CW-1:0]         ram_unread;
    logic                  full_q;
    logic                  overflow_q;

    // Prefetch stage: ram_q is the BRAM output register, hold_data is the older word when both are live.
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  q_valid;
    logic                  hold_valid;
    logic [1:0]            stage_occ;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rd_issue;

    always_comb begin
        wr_acc     = bus.wr_en & ~full_q;
        rd_acc     = (q_valid | hold_valid) & bus.rd_ready;
        stage_occ  = {1'b0, q_valid} + {1'b0, hold_valid};
        // count covers the stage too, so whatever is not in the stage is still in RAM
        ram_unread = count - CW'(stage_occ);
        rd_issue   = (ram_unread != '0) && ((stage_occ - {1'b0, rd_acc}) <= 2'd1);
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_acc) begin
            ram[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ram_q <= '0;
        end else if (rd_issue) begin
            ram_q <= ram[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count  <= count_next;
            full_q <= (count_next == CW'(DEPTH));
            if (bus.wr_en && full_q) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_valid    <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (rd_issue) begin
            q_valid <= 1'b1;
            // The word leaving ram_q survives unless it is the head being consumed now
            if (q_valid && !(rd_acc && !hold_valid)) begin
                hold_data  <= ram_q;
                hold_valid <= 1'b1;
            end else begin
                hold_valid <= hold_valid & ~rd_acc;
            end
        end else if (rd_acc) begin
            if (hold_valid) begin
                hold_valid <= 1'b0;
            end else begin
                q_valid <= 1'b0;
            end
        end
    end

    assign bus.rd_data  = hold_valid ? hold_data : ram_q;
    assign bus.rd_valid = q_valid | hold_valid;
    assign bus.level    = count;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;

`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
    logic afull_q;
    logic aempty_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (count_next >= CW'(AFULL_LEVEL));
            aempty_q <= (count_next <= CW'(AEMPTY_LEVEL));
        end
    end

    assign bus.afull  = afull_q;
    assign bus.aempty = aempty_q;
`endif

endmodule

// File: tb/tb_gtfraw_vnc_sync_fifo_bram.sv
// Bench for gtfraw_vnc_sync_fifo_bram: queue-based reference model checked every cycle on negedge,
// plus literal checks on reset, latency, fill/overflow, streaming and watermark edges.
`timescale 1ns/1ps
module tb_gtfraw_vnc_sync_fifo_bram;
    localparam int DW    = 74;
    localparam int DEPTH = 512;
    localparam int AW    = 9;
    typedef logic [DW-1:0] word_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    gtfraw_vnc_sync_fifo_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    gtfraw_vnc_sync_fifo_bram #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(AW)
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
        ,
        .AFULL_LEVEL(500),
        .AEMPTY_LEVEL(8)
`endif
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    word_t exp_q[$];
    int    acc_q[$];
    logic  m_ovf    = 1'b0;
    logic  model_on = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a word accepted in cycle N is at the head from cycle N+2 at the earliest.
    always @(negedge clk) begin : cmp_proc
        logic m_valid;
        logic m_full;
        logic acc;
        logic pop;
        m_valid = 1'b0;
        if (exp_q.size() > 0) m_valid = (acc_q[0] + 2 <= cyc);
        m_full = (exp_q.size() == DEPTH);
        if (model_on) begin
            check("level", bus.level, exp_q.size());
            check("full", bus.full, m_full);
            check("overflow", bus.overflow, m_ovf);
            check("rd_valid", bus.rd_valid, m_valid);
            if (m_valid) check("rd_data", bus.rd_data, exp_q[0]);
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
            check("afull", bus.afull, exp_q.size() >= 500);
            check("aempty", bus.aempty, exp_q.size() <= 8);
`endif
        end
        if (!rstn) begin
            exp_q.delete();
            acc_q.delete();
            m_ovf    = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            acc = bus.wr_en && !m_full;
            pop = m_valid && bus.rd_ready;
            if (bus.wr_en && m_full) m_ovf = 1'b1;
            else if (bus.clr_ovf) m_ovf = 1'b0;
            if (pop) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(bus.wr_data);
                acc_q.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        bus.clr_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    function automatic word_t rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    initial begin
        idle_inputs();

        // 1: reset state, then first-word latency with rd_ready low
        do_reset();
        bus.wr_en   = 1'b1;
        bus.wr_data = 74'h1234;
        @(negedge clk);
        check("rst_level", bus.level, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_rd_data", bus.rd_data, 0);
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("t1_c1_rd_valid", bus.rd_valid, 0);
        check("t1_c1_level", bus.level, 1);
        tick();
        @(negedge clk);
        check("t1_c2_rd_valid", bus.rd_valid, 1);
        check("t1_c2_rd_data", bus.rd_data, 74'h1234);
        check("t1_c2_level", bus.level, 1);
        tick();

        // 2: fill to full, overflow (set beats clear, read same cycle doesn't help), drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = word_t'(i);
`ifdef GTFRAW_VNC_FIFO_WATERMARK_EN
            if (i == 8 || i == 9 || i == 499 || i == 500) begin
                @(negedge clk);
                check("wm_level", bus.level, i);
                check("wm_afull", bus.afull, i >= 500);
                check("wm_aempty", bus.aempty, i <= 8);
            end
`endif
            tick();
        end
        bus.wr_data = 74'hDEAD;
        bus.clr_ovf = 1'b1;
        @(negedge clk);
        check("t2_full", bus.full, 1);
        check("t2_level", bus.level, DEPTH);
        check("t2_ovf_before", bus.overflow, 0);
        tick();
        bus.clr_ovf  = 1'b0;
        bus.wr_data  = 74'hBEEF;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        check("t2_ovf_set", bus.overflow, 1);
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("t2_full_clear", bus.full, 0);
        check("t2_level_511", bus.level, DEPTH - 1);
        check("t2_ovf_sticky", bus.overflow, 1);
        for (int i = 0; i < DEPTH + 8; i++) tick();
        bus.rd_ready = 1'b0;
        bus.clr_ovf  = 1'b1;
        @(negedge clk);
        check("t2_drained", bus.level, 0);
        tick();
        bus.clr_ovf = 1'b0;
        @(negedge clk);
        check("t2_ovf_cleared", bus.overflow, 0);
        tick();

        // 3: continuous streaming across several pointer wraps
        do_reset();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = word_t'(1000 + i);
            if (i == 2 || i == 777 || i == 1999) begin
                @(negedge clk);
                check("t3_rd_valid", bus.rd_valid, 1);
                check("t3_rd_data", bus.rd_data, word_t'(1000 + i - 2));
                check("t3_level", bus.level, 2);
            end
            tick();
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // 4: random traffic, a filling phase then a draining phase
        do_reset();
        for (int i = 0; i < 1600; i++) begin
            bus.wr_en    = ($urandom_range(0, 3) != 0);
            bus.wr_data  = rand_word();
            bus.rd_ready = ($urandom_range(0, 3) == 0);
            bus.clr_ovf  = ($urandom_range(0, 31) == 0);
            tick();
        end
        for (int i = 0; i < 1600; i++) begin
            bus.wr_en    = ($urandom_range(0, 9) < 3);
            bus.wr_data  = rand_word();
            bus.rd_ready = ($urandom_range(0, 1) == 1);
            bus.clr_ovf  = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle_inputs();
        tick();

        // 5: reset mid-stream discards stored data
        do_reset();
        for (int i = 0; i < 100; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = rand_word();
            tick();
        end
        bus.wr_en = 1'b0;
        tick();
        @(negedge clk);
        check("t5_level_100", bus.level, 100);
        rstn = 1'b0;
        tick();
        rstn        = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 74'hABC;
        @(negedge clk);
        check("t5_level_0", bus.level, 0);
        check("t5_rd_valid_0", bus.rd_valid, 0);
        check("t5_full_0", bus.full, 0);
        tick();
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        check("t5_c1_rd_valid", bus.rd_valid, 0);
        tick();
        @(negedge clk);
        check("t5_c2_rd_valid", bus.rd_valid, 1);
        check("t5_c2_rd_data", bus.rd_data, 74'hABC);
        tick();
        bus.rd_ready = 1'b0;
        tick();
        @(negedge clk);
        check("t5_empty_after", bus.level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
